pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Purpose: fetch/execute sequencer holding the state bit, PC, IR and a small return-address stack.
// Latency: registers update one clk after the control inputs; opcode/eoe/pc_link are combinational decodes.
// Backpressure: none; control inputs are applied every clock until halted, after which everything freezes.
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               NS,
    input  logic [1:0]         PS,
    input  logic               IL,
    input  logic               MP,
    output logic               state,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         eoe,
    output logic [PC_W-1:0]    pc_link,
    output logic               halted,
    output logic               stack_err
);

    // sp counts 0..STACK_DEPTH, so it needs one bit more than the entry index
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W = AW + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] eoe;
        logic [7:0] offset;
    } ifields_t;

    phase_t                phase_q;
    phase_t                phase_d;
    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic [PC_W-1:0]       pc_inc;
    logic [PC_W-1:0]       off_sx;
    logic [INSTR_W-1:0]    instr_q;
    ifields_t              fld;
    logic [SP_W-1:0]       sp_q;
    logic [SP_W-1:0]       sp_d;
    logic [PC_W-1:0]       stack_q [STACK_DEPTH];
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         push_idx;
    logic                  push_we;
    logic                  pop_ok;
    logic                  underflow;
    logic                  overflow;
    logic                  err_set;
    logic                  halted_q;
    logic                  err_q;
    logic                  halt_now;
    logic                  run;
    logic                  ir_load;

    assign fld = ifields_t'(instr_q[15:0]);

    // Halt is detected on the current IR while executing; the halting edge itself already freezes state
    always_comb begin
        halt_now = 1'b0;
        run      = 1'b0;
        ir_load  = 1'b0;
        halt_now = (phase_q == EXEC) && (fld.opcode == 4'hF) && (fld.eoe == 4'hF);
        run      = !halted_q && !halt_now;
        ir_load  = IL && (phase_q == FETCH);
    end

    // Next state is the complement of whatever the control logic echoed back, even if the echo is wrong
    always_comb begin
        phase_d = phase_q;
        if (run) begin
            phase_d = phase_t'(~NS);
        end
    end

    // Sign-extend (or truncate) the 8-bit branch offset to the PC width
    always_comb begin
        off_sx = '0;
        for (int i = 0; i < PC_W; i++) begin
            off_sx[i] = fld.offset[3'((i < 8) ? i : 7)];
        end
    end

    // PC select and return-stack bookkeeping; push+pop reuses the popped slot so sp stays put
    always_comb begin
        pc_inc    = pc_q + PC_W'(1);
        top_idx   = AW'(sp_q - SP_W'(1));
        pop_ok    = (PS == 2'b11) && (sp_q != '0);
        underflow = (PS == 2'b11) && (sp_q == '0);
        pc_d      = pc_q;
        sp_d      = sp_q;
        push_we   = 1'b0;
        push_idx  = top_idx;
        overflow  = 1'b0;

        case (PS)
            2'b00:   pc_d = pc_q;
            2'b01:   pc_d = pc_inc;
            2'b10:   pc_d = pc_q + off_sx;
            default: pc_d = pop_ok ? stack_q[top_idx] : pc_inc;
        endcase

        if (MP) begin
            if (pop_ok) begin
                push_we  = 1'b1;
                push_idx = top_idx;
            end else if (sp_q == SP_FULL) begin
                overflow = 1'b1;
            end else begin
                push_we  = 1'b1;
                push_idx = AW'(sp_q);
                sp_d     = sp_q + SP_W'(1);
            end
        end else if (pop_ok) begin
            sp_d = sp_q - SP_W'(1);
        end

        err_set = overflow || underflow;
    end

    // Machine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    // PC, IR, stack and error flag; all hold once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (run) begin
            pc_q <= pc_d;
            sp_q <= sp_d;
            if (ir_load) begin
                instr_q <= instr_in;
            end
            if (push_we) begin
                stack_q[push_idx] <= pc_inc;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_q | halt_now;
        end
    end

    assign state     = phase_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = fld.opcode;
    assign eoe       = fld.eoe;
    assign pc_link   = pc_inc;
    assign halted    = halted_q;
    assign stack_err = err_q;

endmodule
